// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//
// Carries each M-stage load/store to one of three targets: data memory (DM),
// timer 1 (TC1) or timer 2 (TC2). The pipeline stalls until the access
// completes. Address and range faults are reported on cpu_err, and so are DM
// accesses that get no ack within TIMEOUT cycles.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/byteen
//                     access request from the CPU; the CPU holds these while
//                     stalled
//   cpu_stall         freezes the pipeline while an access is in flight
//   cpu_rdata         registered load data (raw word)
//   cpu_rvalid        one-cycle pulse when a load completes without error
//   cpu_err           one-cycle pulse when an access faults
//   dm_req/we/addr/wdata/byteen, dm_ack, dm_rdata
//                     request/ack handshake to a variable-latency data memory
//   tcN_we/addr/wdata, tcN_rdata
//                     single-cycle register access to timer N (N = 1, 2)
module mem_bus_bridge #(
  parameter logic [31:0] DM_END   = 32'h0000_2fff,
  parameter logic [31:0] TC1_BASE = 32'h0000_7f00,
  parameter logic [31:0] TC2_BASE = 32'h0000_7f10,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        tc1_we,
  output logic [1:0]  tc1_addr,
  output logic [31:0] tc1_wdata,
  input  logic [31:0] tc1_rdata,
  output logic        tc2_we,
  output logic [1:0]  tc2_addr,
  output logic [31:0] tc2_wdata,
  input  logic [31:0] tc2_rdata
);

  typedef enum logic [1:0] {IDLE, DM_BUSY, TC_ACC, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        lat_we;
  logic [31:2] lat_word;   // only word bits are ever needed after decode
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byteen;
  logic        lat_err;
  logic        lat_sel2;   // 1: timer access targets TC2, 0: TC1
  logic [7:0]  tmo_cnt;

  logic in_dm, in_tc1, in_tc2, is_tc, dec_err, tmo_hit;

  // Decode the CPU request directly so that the IDLE edge can already pick
  // the next state; an error costs only the single IDLE stall cycle.
  always_comb begin
    in_dm   = (cpu_addr <= DM_END);
    in_tc1  = (cpu_addr >= TC1_BASE) && (cpu_addr <= TC1_BASE + 32'hb);
    in_tc2  = (cpu_addr >= TC2_BASE) && (cpu_addr <= TC2_BASE + 32'hb);
    is_tc   = in_tc1 || in_tc2;
    dec_err = !(in_dm || is_tc)
           || (is_tc && cpu_we && (cpu_byteen != 4'hf))
           || (is_tc && (cpu_addr[1:0] != 2'b00))
           || (!cpu_we && (cpu_addr[1:0] != 2'b00));
    tmo_hit = (tmo_cnt == TMO_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (dec_err)    state_nxt = DONE;
          else if (in_dm) state_nxt = DM_BUSY;
          else            state_nxt = TC_ACC;
        end
      end
      // An ack in the timeout cycle still completes normally; only the
      // error flag differs, and that is handled in the latch block.
      DM_BUSY: if (dm_ack || tmo_hit) state_nxt = DONE;
      TC_ACC:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, timeout counter and load data register
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
      lat_err    <= 1'b0;
      lat_sel2   <= 1'b0;
      tmo_cnt    <= '0;
      cpu_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_we     <= cpu_we;
            lat_word   <= cpu_addr[31:2];
            lat_wdata  <= cpu_wdata;
            lat_byteen <= cpu_byteen;
            lat_err    <= dec_err;
            lat_sel2   <= in_tc2;
            tmo_cnt    <= '0;
          end
        end
        DM_BUSY: begin
          if (dm_ack) begin
            if (!lat_we) cpu_rdata <= dm_rdata;
          end else if (tmo_hit) begin
            lat_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        TC_ACC: begin
          if (!lat_we) cpu_rdata <= lat_sel2 ? tc2_rdata : tc1_rdata;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    cpu_stall  = (state == IDLE) ? cpu_req : ((state == DM_BUSY) || (state == TC_ACC));
    cpu_rvalid = (state == DONE) && !lat_err && !lat_we;
    cpu_err    = (state == DONE) && lat_err;

    dm_req     = (state == DM_BUSY);
    dm_we      = (state == DM_BUSY) && lat_we;
    dm_addr    = {lat_word, 2'b00};
    dm_wdata   = lat_wdata;
    dm_byteen  = lat_byteen;

    // Timer ranges are 16-byte aligned, so the register index is the
    // word-offset bits minus the (zero) base bits.
    tc1_addr   = lat_word[3:2] - TC1_BASE[3:2];
    tc2_addr   = lat_word[3:2] - TC2_BASE[3:2];
    tc1_wdata  = lat_wdata;
    tc2_wdata  = lat_wdata;
    tc1_we     = (state == TC_ACC) && lat_we && !lat_sel2;
    tc2_we     = (state == TC_ACC) && lat_we && lat_sel2;
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;
  logic        tc1_we, tc2_we;
  logic [1:0]  tc1_addr, tc2_addr;
  logic [31:0] tc1_wdata, tc2_wdata, tc1_rdata, tc2_rdata;

  mem_bus_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_byteen(dm_byteen),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .tc1_we(tc1_we), .tc1_addr(tc1_addr), .tc1_wdata(tc1_wdata), .tc1_rdata(tc1_rdata),
    .tc2_we(tc2_we), .tc2_addr(tc2_addr), .tc2_wdata(tc2_wdata), .tc2_rdata(tc2_rdata)
  );

  always #5 clk = ~clk;

  logic [174:0] all_out;
  assign all_out = {cpu_stall, cpu_rdata, cpu_rvalid, cpu_err, dm_req, dm_we, dm_addr,
                    dm_wdata, dm_byteen, tc1_we, tc1_addr, tc1_wdata, tc2_we, tc2_addr, tc2_wdata};

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered by run_access
  int          stalls, busy, rv_cnt, err_cnt, dmreq_cnt, tc1we_cnt, tc2we_cnt;
  logic [31:0] obs_dm_addr, obs_dm_wdata, obs_tc2_wdata;
  logic        obs_dm_we;
  logic [3:0]  obs_dm_be;
  logic [1:0]  obs_tc1_addr, obs_tc2_addr;
  logic [31:0] exp_rdata;

  // Issue one access starting in an IDLE cycle (called at a falling edge) and
  // return at the falling edge of the IDLE cycle following DONE.
  // ack_dly: DM_BUSY cycle index (0-based) in which dm_ack is pulsed; -1 = never.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input int ack_dly, input logic [31:0] rd);
    bit done;
    done = 0;
    stalls = 0; busy = 0; rv_cnt = 0; err_cnt = 0; dmreq_cnt = 0; tc1we_cnt = 0; tc2we_cnt = 0;
    obs_dm_addr = 'x; obs_dm_wdata = 'x; obs_dm_we = 'x; obs_dm_be = 'x;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_byteen = be;
    dm_rdata = rd; dm_ack = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (cpu_stall) begin
        stalls++;
        obs_tc1_addr = tc1_addr; obs_tc2_addr = tc2_addr; obs_tc2_wdata = tc2_wdata;
      end
      if (tc1_we) tc1we_cnt++;
      if (tc2_we) tc2we_cnt++;
      if (cpu_rvalid) rv_cnt++;
      if (cpu_err) err_cnt++;
      dm_ack = 1'b0;
      if (dm_req) begin
        if (busy == 0) begin
          obs_dm_addr = dm_addr; obs_dm_wdata = dm_wdata; obs_dm_we = dm_we; obs_dm_be = dm_byteen;
        end
        dm_ack = (busy == ack_dly);
        busy++;
        dmreq_cnt++;
      end
      if (!cpu_stall) done = 1;
      @(negedge clk);
    end
    cpu_req = 1'b0; dm_ack = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL access_done addr=%h: no completion within 100 cycles, required completion", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_byteen = 0;
    dm_ack = 0; dm_rdata = 0; tc1_rdata = 0; tc2_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h required 0", all_out); end
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL post_reset_idle: got %h required 0", all_out); end
    @(negedge clk);
    exp_rdata = 32'h0;
  endtask

  task automatic test_dm_load();
    run_access(1'b0, 32'h0000_0104, 32'h0, 4'hf, 2, 32'hDEAD_BEEF);
    exp_rdata = 32'hDEAD_BEEF;
    n_cmp++; if (obs_dm_addr !== 32'h104) begin n_bad++; $display("FAIL dm_load_addr: got %h required 104", obs_dm_addr); end
    n_cmp++; if (obs_dm_we !== 1'b0) begin n_bad++; $display("FAIL dm_load_we: got %b required 0", obs_dm_we); end
    n_cmp++; if (stalls != 4) begin n_bad++; $display("FAIL dm_load_stalls: got %0d required 4", stalls); end
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL dm_load_rdata: got %h required %h", cpu_rdata, exp_rdata); end
    n_cmp++; if (rv_cnt != 1 || err_cnt != 0) begin n_bad++; $display("FAIL dm_load_pulses: rvalid %0d err %0d required 1 0", rv_cnt, err_cnt); end
  endtask

  task automatic test_dm_store();
    run_access(1'b1, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 0, 32'h0);
    n_cmp++; if (obs_dm_addr !== 32'h200) begin n_bad++; $display("FAIL dm_store_addr: got %h required 200", obs_dm_addr); end
    n_cmp++; if (obs_dm_we !== 1'b1) begin n_bad++; $display("FAIL dm_store_we: got %b required 1", obs_dm_we); end
    n_cmp++; if (obs_dm_be !== 4'b1000) begin n_bad++; $display("FAIL dm_store_byteen: got %b required 1000", obs_dm_be); end
    n_cmp++; if (obs_dm_wdata !== 32'hAB00_0000) begin n_bad++; $display("FAIL dm_store_wdata: got %h required ab000000", obs_dm_wdata); end
    n_cmp++; if (stalls != 2) begin n_bad++; $display("FAIL dm_store_stalls: got %0d required 2", stalls); end
    n_cmp++; if (rv_cnt != 0 || err_cnt != 0) begin n_bad++; $display("FAIL dm_store_pulses: rvalid %0d err %0d required 0 0", rv_cnt, err_cnt); end
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL dm_store_rdata_hold: got %h required %h", cpu_rdata, exp_rdata); end
  endtask

  task automatic test_timers();
    run_access(1'b1, 32'h0000_7f14, 32'h5, 4'hf, -1, 32'h0);
    n_cmp++; if (obs_tc2_addr !== 2'd1) begin n_bad++; $display("FAIL tc2_store_addr: got %0d required 1", obs_tc2_addr); end
    n_cmp++; if (obs_tc2_wdata !== 32'h5) begin n_bad++; $display("FAIL tc2_store_wdata: got %h required 5", obs_tc2_wdata); end
    n_cmp++; if (tc2we_cnt != 1 || tc1we_cnt != 0) begin n_bad++; $display("FAIL tc2_store_we: tc2 %0d tc1 %0d required 1 0", tc2we_cnt, tc1we_cnt); end
    n_cmp++; if (stalls != 2 || dmreq_cnt != 0) begin n_bad++; $display("FAIL tc2_store_stalls: stalls %0d dmreq %0d required 2 0", stalls, dmreq_cnt); end
    tc2_rdata = 32'h5;
    run_access(1'b0, 32'h0000_7f14, 32'h0, 4'hf, -1, 32'h0);
    exp_rdata = 32'h5;
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL tc2_load_rdata: got %h required 5", cpu_rdata); end
    n_cmp++; if (stalls != 2 || rv_cnt != 1 || tc2we_cnt != 0) begin n_bad++; $display("FAIL tc2_load_ctl: stalls %0d rvalid %0d we %0d required 2 1 0", stalls, rv_cnt, tc2we_cnt); end
    tc1_rdata = 32'h1234;
    run_access(1'b0, 32'h0000_7f08, 32'h0, 4'hf, -1, 32'h0);
    exp_rdata = 32'h1234;
    n_cmp++; if (obs_tc1_addr !== 2'd2) begin n_bad++; $display("FAIL tc1_load_addr: got %0d required 2", obs_tc1_addr); end
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL tc1_load_rdata: got %h required 1234", cpu_rdata); end
  endtask

  task automatic test_faults();
    logic [31:0] f_addr [5] = '{32'h0000_3000, 32'h0000_7f0c, 32'h0000_7f00, 32'h0000_0002, 32'h0000_7f1c};
    logic        f_we   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  f_be   [5] = '{4'hf, 4'hf, 4'b0011, 4'hf, 4'hf};
    for (int i = 0; i < 5; i++) begin
      run_access(f_we[i], f_addr[i], 32'h9999_9999, f_be[i], 0, 32'h7777_7777);
      n_cmp++;
      if (stalls != 1 || err_cnt != 1 || rv_cnt != 0 || dmreq_cnt != 0 || tc1we_cnt != 0 || tc2we_cnt != 0) begin
        n_bad++;
        $display("FAIL fault_%0d addr=%h: stalls %0d err %0d rvalid %0d dmreq %0d tcwe %0d/%0d required 1 1 0 0 0/0",
                 i, f_addr[i], stalls, err_cnt, rv_cnt, dmreq_cnt, tc1we_cnt, tc2we_cnt);
      end
      n_cmp++;
      if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL fault_%0d_rdata: got %h required %h", i, cpu_rdata, exp_rdata); end
    end
  endtask

  task automatic test_timeout();
    int stray;
    run_access(1'b0, 32'h0000_0010, 32'h0, 4'hf, -1, 32'h4444_4444);
    n_cmp++; if (stalls != 17 || busy != 16) begin n_bad++; $display("FAIL timeout_len: stalls %0d busy %0d required 17 16", stalls, busy); end
    n_cmp++; if (err_cnt != 1 || rv_cnt != 0) begin n_bad++; $display("FAIL timeout_pulses: err %0d rvalid %0d required 1 0", err_cnt, rv_cnt); end
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL timeout_rdata: got %h required %h", cpu_rdata, exp_rdata); end
    // Idle cycles with a late ack on the 5th; nothing may react.
    stray = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (dm_req || cpu_stall || cpu_rvalid || cpu_err) stray++;
      dm_ack = (c == 4);
      @(negedge clk);
    end
    dm_ack = 1'b0;
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL late_ack_ignored: active cycles %0d required 0", stray); end
    run_access(1'b0, 32'h0000_2ffc, 32'h0, 4'hf, 0, 32'h1122_3344);
    exp_rdata = 32'h1122_3344;
    n_cmp++; if (stalls != 2 || rv_cnt != 1 || cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL after_timeout_load: stalls %0d rvalid %0d rdata %h required 2 1 %h", stalls, rv_cnt, cpu_rdata, exp_rdata); end
    run_access(1'b0, 32'h0000_0020, 32'h0, 4'hf, 15, 32'h0BAD_CAFE);
    exp_rdata = 32'h0BAD_CAFE;
    n_cmp++; if (stalls != 17 || rv_cnt != 1 || err_cnt != 0) begin n_bad++; $display("FAIL ack_at_limit: stalls %0d rvalid %0d err %0d required 17 1 0", stalls, rv_cnt, err_cnt); end
    n_cmp++; if (cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL ack_at_limit_rdata: got %h required %h", cpu_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid_busy();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h0; cpu_byteen = 4'hf; dm_ack = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (dm_req !== 1'b1) begin n_bad++; $display("FAIL mid_busy_req: got %b required 1", dm_req); end
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL mid_busy_reset_outputs: got %h required 0", all_out); end
    reset = 1'b0;
    @(negedge clk);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    n_cmp++; if ({dm_req, cpu_stall, cpu_rvalid, cpu_err} !== 4'b0) begin n_bad++; $display("FAIL stray_ack_after_reset: got %b required 0000", {dm_req, cpu_stall, cpu_rvalid, cpu_err}); end
    @(negedge clk);
    run_access(1'b0, 32'h0000_0080, 32'h0, 4'hf, 1, 32'hCAFE_F00D);
    exp_rdata = 32'hCAFE_F00D;
    n_cmp++; if (stalls != 3 || rv_cnt != 1 || cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL load_after_reset: stalls %0d rvalid %0d rdata %h required 3 1 %h", stalls, rv_cnt, cpu_rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 32'h0000_7f04, 32'h77, 4'hf, -1, 32'h0);
    n_cmp++; if (tc1we_cnt != 1 || tc2we_cnt != 0 || stalls != 2) begin n_bad++; $display("FAIL b2b_first: tc1we %0d tc2we %0d stalls %0d required 1 0 2", tc1we_cnt, tc2we_cnt, stalls); end
    n_cmp++; if (obs_tc1_addr !== 2'd1) begin n_bad++; $display("FAIL b2b_tc1_addr: got %0d required 1", obs_tc1_addr); end
    run_access(1'b0, 32'h0000_2ffc, 32'h0, 4'hf, 0, 32'h55AA_55AA);
    exp_rdata = 32'h55AA_55AA;
    n_cmp++; if (stalls != 2 || rv_cnt != 1 || cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL b2b_second: stalls %0d rvalid %0d rdata %h required 2 1 %h", stalls, rv_cnt, cpu_rdata, exp_rdata); end
  endtask

  initial begin
    test_reset();
    test_dm_load();
    test_dm_store();
    test_timers();
    test_faults();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
